// File: rtl/qdec_pkg.sv
// Shared types and default widths for the quadrature decoder.
package qdec_pkg;

  localparam int QDEC_POS_W = 16;
  localparam int QDEC_ERR_W = 8;

  typedef enum logic {
    TRACK = 1'b0,
    FAULT = 1'b1
  } qdec_state_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UP      = 2'd1,
    DOWN    = 2'd2,
    ILLEGAL = 2'd3
  } qdec_step_e;

endpackage

// File: rtl/qdec_step_decode.sv
// Classifies one AB transition (prev -> cur) of a quadrature encoder.
module qdec_step_decode
  import qdec_pkg::*;
(
  input  logic [1:0] i_prev,
  input  logic [1:0] i_cur,
  output qdec_step_e o_step
);

  always_comb begin
    // NOTE: assign a default before any branch so no path leaves o_step unassigned (no latch).
    o_step = ILLEGAL;
    if (i_prev == i_cur) begin
      o_step = IDLE;
    end else begin
      // Forward Gray order is 00 -> 10 -> 11 -> 01 -> 00.
      case ({i_prev, i_cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: o_step = UP;
        4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: o_step = DOWN;
        default:                                o_step = ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: position counter, direction, step pulse and FAULT lockout.
// Define QDEC_ERR_CNT_EN to build the saturating illegal-transition counter; otherwise err_cnt is tied to 0.
module quad_decoder
  import qdec_pkg::*;
#(
  parameter int POS_W = QDEC_POS_W,
  parameter int ERR_W = QDEC_ERR_W
) (
  input  logic                    clk,
  input  logic                    arst_n,
  input  logic [1:0]              hist_a,
  input  logic [1:0]              hist_b,
  input  logic                    en,
  input  logic                    clr,
  output logic signed [POS_W-1:0] pos,
  output logic                    step_vld,
  output logic                    dir,
  output logic                    fault,
  output logic [ERR_W-1:0]        err_cnt
);

  qdec_step_e               w_step;
  qdec_state_e              r_state;
  logic signed [POS_W-1:0]  r_pos;
  logic                     r_step_vld;
  logic                     r_dir;
  logic                     r_fault;

  qdec_step_decode u_step_decode (
    .i_prev (({hist_a[1], hist_b[1]})),
    .i_cur  (({hist_a[0], hist_b[0]})),
    .o_step (w_step)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= TRACK;
      r_pos      <= '0;
      r_step_vld <= 1'b0;
      r_dir      <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_step_vld <= 1'b0;
      if (clr) begin
        r_state <= TRACK;
        r_pos   <= '0;
        r_fault <= 1'b0;
      end else if (en) begin
        case (r_state)
          TRACK: begin
            case (w_step)
              UP: begin
                r_pos      <= r_pos + POS_W'(1);
                r_dir      <= 1'b1;
                r_step_vld <= 1'b1;
              end
              DOWN: begin
                r_pos      <= r_pos - POS_W'(1);
                r_dir      <= 1'b0;
                r_step_vld <= 1'b1;
              end
              ILLEGAL: begin
                r_state <= FAULT;
                r_fault <= 1'b1;
              end
              default: ;
            endcase
          end
          default: ;  // FAULT holds everything until clr
        endcase
      end
    end
  end

  assign pos      = r_pos;
  assign step_vld = r_step_vld;
  assign dir      = r_dir;
  assign fault    = r_fault;

`ifdef QDEC_ERR_CNT_EN
  logic [ERR_W-1:0] r_err_cnt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_err_cnt <= '0;
    end else if (clr) begin
      r_err_cnt <= '0;
    end else if (en && (w_step == ILLEGAL) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_W'(1);
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: a 16-bit and a 4-bit/2-bit instance share one stimulus stream.
module tb_quad_decoder;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [1:0]  hist_a = 2'b00;
  logic [1:0]  hist_b = 2'b00;
  logic        en = 1'b0;
  logic        clr = 1'b0;

  logic signed [15:0] pos16;
  logic               vld16, dir16, fault16;
  logic [7:0]         err16;
  logic signed [3:0]  pos4;
  logic               vld4, dir4, fault4;
  logic [1:0]         err4;

  quad_decoder #(.POS_W(16), .ERR_W(8)) dut_w16 (
    .clk(clk), .arst_n(arst_n), .hist_a(hist_a), .hist_b(hist_b), .en(en), .clr(clr),
    .pos(pos16), .step_vld(vld16), .dir(dir16), .fault(fault16), .err_cnt(err16)
  );

  quad_decoder #(.POS_W(4), .ERR_W(2)) dut_w4 (
    .clk(clk), .arst_n(arst_n), .hist_a(hist_a), .hist_b(hist_b), .en(en), .clr(clr),
    .pos(pos4), .step_vld(vld4), .dir(dir4), .fault(fault4), .err_cnt(err4)
  );

  always #5 clk = ~clk;

`ifdef QDEC_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  // Reference model: unbounded position, raw error count, fault flag.
  int   m_pos = 0;
  int   m_err = 0;
  logic m_dir = 1'b0;
  logic m_fault = 1'b0;
  logic m_vld = 1'b0;

  // Position of each AB code along the forward cycle 00,10,11,01.
  int gray_idx [4] = '{0, 3, 1, 2};

  typedef struct {
    logic a;
    logic b;
    int   exp_pos;
    logic exp_vld;
    logic exp_dir;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int err_exp(input int raw, input int maxv);
    int v;
    v = (raw > maxv) ? maxv : raw;
    return ERR_EN ? v : 0;
  endfunction

  task automatic model_step();
    int p, c, d;
    m_vld = 1'b0;
    if (clr) begin
      m_pos = 0;
      m_err = 0;
      m_fault = 1'b0;
    end else if (en) begin
      p = gray_idx[{hist_a[1], hist_b[1]}];
      c = gray_idx[{hist_a[0], hist_b[0]}];
      d = (c - p + 4) % 4;
      if (d == 2) begin
        m_err++;
        m_fault = 1'b1;
      end else if (!m_fault && d == 1) begin
        m_pos++;
        m_dir = 1'b1;
        m_vld = 1'b1;
      end else if (!m_fault && d == 3) begin
        m_pos--;
        m_dir = 1'b0;
        m_vld = 1'b1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check($sformatf("%s pos16", tag), 32'({pos16}), 32'(m_pos[15:0]));
    check($sformatf("%s pos4", tag), 32'({pos4}), 32'(m_pos[3:0]));
    check($sformatf("%s vld16", tag), 32'(vld16), 32'(m_vld));
    check($sformatf("%s vld4", tag), 32'(vld4), 32'(m_vld));
    check($sformatf("%s dir16", tag), 32'(dir16), 32'(m_dir));
    check($sformatf("%s dir4", tag), 32'(dir4), 32'(m_dir));
    check($sformatf("%s fault16", tag), 32'(fault16), 32'(m_fault));
    check($sformatf("%s fault4", tag), 32'(fault4), 32'(m_fault));
    check($sformatf("%s err16", tag), 32'(err16), 32'(err_exp(m_err, 255)));
    check($sformatf("%s err4", tag), 32'(err4), 32'(err_exp(m_err, 3)));
  endtask

  // Called on a falling edge: shift in one AB sample, clock once, return on the next falling edge.
  task automatic drive(input logic a, input logic b, input logic e, input logic c);
    hist_a = {hist_a[0], a};
    hist_b = {hist_b[0], b};
    en = e;
    clr = c;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s pos16", tag), 32'({pos16}), 32'd0);
    check($sformatf("%s pos4", tag), 32'({pos4}), 32'd0);
    check($sformatf("%s vld", tag), 32'({vld16, vld4}), 32'd0);
    check($sformatf("%s dir", tag), 32'({dir16, dir4}), 32'd0);
    check($sformatf("%s fault", tag), 32'({fault16, fault4}), 32'd0);
    check($sformatf("%s err16", tag), 32'(err16), 32'd0);
    check($sformatf("%s err4", tag), 32'(err4), 32'd0);
  endtask

  initial begin
    int e;
    logic [1:0] ab;
    int r;

    // Reset state, checked before any clock edge.
    #1;
    check_all_zero("reset");
    @(negedge clk);
    arst_n = 1'b1;

    // Forward x2 then reverse x3; the 4-bit instance wraps 7 -> -8 and back to 7.
    tbl.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 2, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 3, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 4, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 5, 1'b1, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 6, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 7, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 8, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 7, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 6, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 5, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 4, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 3, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 2, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b1, -1, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b1, -2, 1'b1, 1'b0});
    tbl.push_back('{1'b1, 1'b0, -3, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, -4, 1'b1, 1'b0});

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].a, tbl[i].b, 1'b1, 1'b0);
      e = tbl[i].exp_pos;
      check($sformatf("tbl[%0d] pos16", i), 32'({pos16}), 32'(e[15:0]));
      check($sformatf("tbl[%0d] pos4", i), 32'({pos4}), 32'(e[3:0]));
      check($sformatf("tbl[%0d] vld", i), 32'(vld16), 32'(tbl[i].exp_vld));
      check($sformatf("tbl[%0d] dir", i), 32'(dir16), 32'(tbl[i].exp_dir));
      check($sformatf("tbl[%0d] fault", i), 32'(fault16), 32'd0);
      compare_all($sformatf("tbl[%0d]", i));
    end
    check("rev pos16 0xFFFC", 32'({pos16}), 32'h0000_FFFC);

    // Illegal 00->11: fault, frozen position, then clr coincident with an UP.
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("illegal fault", 32'(fault16), 32'd1);
    check("illegal err16", 32'(err16), 32'(err_exp(1, 255)));
    compare_all("illegal");
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("frozen pos", 32'({pos16}), 32'd0);
    check("frozen vld", 32'(vld16), 32'd0);
    compare_all("frozen");
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    check("clr fault", 32'(fault16), 32'd0);
    check("clr err16", 32'(err16), 32'd0);
    compare_all("clr");

    // Five illegal transitions: 2-bit counter saturates at 3.
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("sat err4", 32'(err4), 32'(ERR_EN ? 3 : 0));
    check("sat err16", 32'(err16), 32'(ERR_EN ? 5 : 0));
    compare_all("sat");
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    compare_all("sat clr");

    // clr wins over a same-cycle UP; dir holds its last value.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("pre-prio pos", 32'({pos16}), 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("prio pos", 32'({pos16}), 32'd0);
    check("prio vld", 32'(vld16), 32'd0);
    check("prio dir", 32'(dir16), 32'd1);
    compare_all("prio");

    // en=0: four legal steps and one illegal are ignored.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("en0 pos", 32'({pos16}), 32'h0000_FFFF);
    check("en0 vld", 32'(vld16), 32'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("en0 fault", 32'(fault16), 32'd0);
    compare_all("en0");

    // Asynchronous reset between clock edges.
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    arst_n = 1'b0;
    hist_a = 2'b00;
    hist_b = 2'b00;
    en = 1'b0;
    clr = 1'b0;
    #1;
    check_all_zero("async");
    m_pos = 0; m_err = 0; m_dir = 1'b0; m_fault = 1'b0; m_vld = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("post-reset pos", 32'({pos16}), 32'd1);
    compare_all("post-reset");

    // Randomised stream against the model.
    for (int i = 0; i < 600; i++) begin
      ab = {hist_a[0], hist_b[0]};
      r = $urandom_range(0, 99);
      if (r < 60)      ab = ab ^ ($urandom_range(0, 1) ? 2'b01 : 2'b10);
      else if (r < 85) ab = ab;
      else             ab = 2'($urandom_range(0, 3));
      drive(ab[1], ab[0], $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
      compare_all($sformatf("rnd[%0d]", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 SHALL have parameter POS_W, default 16, position counter width in bits (signed two's complement).
REQ-002 SHALL have parameter ERR_W, default 8, error counter width in bits (unsigned).
REQ-003 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-004 SHALL have port arst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port hist_a, input, 2, channel A sample history from the upstream 2-stage shifter; bit0 newest, bit1 previous.
REQ-006 SHALL have port hist_b, input, 2, channel B sample history; same bit ordering as hist_a.
REQ-007 SHALL have port en, input, 1, decode enable; 0 means inputs are ignored.
REQ-008 SHALL have port clr, input, 1, synchronous clear of pos, err_cnt and FAULT state.
REQ-009 SHALL have port pos, output, POS_W, signed accumulated position.
REQ-010 SHALL have port step_vld, output, 1, one-cycle pulse per legal step.
REQ-011 SHALL have port dir, output, 1, direction of last legal step; 1 means up, 0 means down.
REQ-012 SHALL have port fault, output, 1, high while FSM is in FAULT.
REQ-013 SHALL have port err_cnt, output, ERR_W, count of illegal transitions.

Function
REQ-014 SHALL form prev={hist_a[1],hist_b[1]} and cur={hist_a[0],hist_b[0]} (AB order) each cycle.
REQ-015 SHALL classify prev->cur as UP for 00->10, 10->11, 11->01, 01->00.
REQ-016 SHALL classify prev->cur as DOWN for the reverse transitions.
REQ-017 SHALL classify prev==cur as IDLE and any both-bits-changed transition as ILLEGAL.
REQ-018 SHALL implement FSM states TRACK and FAULT; TRACK->FAULT on ILLEGAL with en=1; FAULT->TRACK only on clr.
REQ-019 SHALL, in TRACK with en=1, on UP: pos+1, dir=1, step_vld=1 on the next cycle (latency 1).
REQ-020 SHALL, in TRACK with en=1, on DOWN: pos-1, dir=0, step_vld=1 on the next cycle.
REQ-021 SHALL wrap pos modulo 2^POS_W (max+1 -> min, min-1 -> max) with no flag.
REQ-022 SHALL freeze pos and dir and hold step_vld=0 while in FAULT.
REQ-023 SHALL increment err_cnt on every ILLEGAL with en=1, in either state, saturating at 2^ERR_W-1.
REQ-024 SHALL ignore hist_a/hist_b entirely when en=0: no step, no error, no state change.
REQ-025 SHALL give clr priority over any same-cycle step or error: next cycle pos=0, err_cnt=0, state TRACK, step_vld=0; dir is held.
REQ-026 SHALL drive all outputs from registers.

Reset
REQ-027 SHALL, while arst_n=0, force pos=0, dir=0, step_vld=0, fault=0, err_cnt=0, state TRACK, independent of clk.
REQ-028 SHALL treat reset mid-step as aborting that step; the first cycle after release decodes normally (upstream all-zero history decodes as IDLE).

Configuration
REQ-029 SHALL honour macro QDEC_ERR_CNT_EN: when defined, err_cnt behaves per REQ-023.
REQ-030 SHALL, when QDEC_ERR_CNT_EN is undefined, keep the err_cnt port, drive it constant 0, and infer no counter; FAULT behaviour is unchanged.

Structure
REQ-031 SHALL place in package qdec_pkg: the FSM state enum (TRACK, FAULT), the step-class enum (IDLE, UP, DOWN, ILLEGAL), and default POS_W/ERR_W constants.
REQ-032 SHALL put the prev/cur classification in combinational sub-module qdec_step_decode, outputting the step-class enum; quad_decoder instantiates it once.

Verification
REQ-033 SHALL cover forward rotation: en=1, AB sequence 00,10,11,01,00 x2 through upstream shifter -> 8 step_vld pulses, dir=1, pos=8.
REQ-034 SHALL cover reverse: from pos=8 drive 00,01,11,10,00 x3 -> pos=-4 (0xFFFC at POS_W=16), dir=0.
REQ-035 SHALL cover wrap: POS_W=4, 8 UP steps from pos=0 -> pos=-8; one DOWN -> pos=7.
REQ-036 SHALL cover illegal: AB 00->11 -> fault=1 next cycle, err_cnt=1; further legal steps leave pos unchanged; clr -> fault=0, pos=0, err_cnt=0.
REQ-037 SHALL cover saturation and priority: ERR_W=2, 5 illegal transitions -> err_cnt=3; clr coincident with UP -> pos=0, step_vld=0.
REQ-038 SHALL cover async reset and enable: arst_n low mid-stream -> all outputs 0 before next clk edge; en=0 with 4 legal steps -> pos unchanged, no pulses.
